// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Accumulator width: product width plus guard bits for C_NUM additions.
    function automatic int acc_w(input int d_w, input int c_w, input int c_num);
        return d_w + c_w + $clog2(c_num);
    endfunction

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round half-up by C_W-1 fractional bits, then saturate to a signed D_W sample.
module fir_round_sat #(
    parameter int ACC_W = 38,
    parameter int D_W   = 16,
    parameter int C_W   = 16
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [D_W-1:0]   o_data
);

    localparam logic signed [ACC_W:0] W_RND = (ACC_W+1)'(1) <<< (C_W - 2);
    localparam logic signed [ACC_W:0] W_MAX = ((ACC_W+1)'(1) <<< (D_W - 1)) - (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] W_MIN = ~W_MAX;

    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shift;

    // One extra bit so the rounding constant can never wrap the sum.
    assign w_sum   = {i_acc[ACC_W-1], i_acc} + W_RND;
    assign w_shift = w_sum >>> (C_W - 1);

    always_comb begin
        o_data = w_shift[D_W-1:0];
        if (w_shift > W_MAX) begin
            o_data = W_MAX[D_W-1:0];
        end else if (w_shift < W_MIN) begin
            o_data = W_MIN[D_W-1:0];
        end
    end

endmodule

// File: rtl/fir_multi_ch.sv
// Time-multiplexed FIR: per-channel delay lines, one shared coefficient bank,
// a single multiplier stepping through the taps one per clock.
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes allowed
//   MAC   | accumulating h[k]*x[ch][k], k = 0..C_NUM-1
//   ROUND | registering the rounded, saturated result
//   OUT   | holding the result until the consumer takes it
module fir_multi_ch
    import fir_pkg::*;
#(
    parameter int  D_W   = 16,
    parameter int  C_W   = 16,
    parameter int  C_NUM = 33,
    parameter int  N_CH  = 4,
    localparam int CH_W  = ch_w(N_CH),
    localparam int A_W   = $clog2(C_NUM),
    localparam int ACC_W = acc_w(D_W, C_W, C_NUM)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [D_W-1:0] in_data,
    input  logic [CH_W-1:0]       in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [D_W-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  coef_wr_en,
    input  logic [A_W-1:0]        coef_addr,
    input  logic signed [C_W-1:0] coef_data,
    output logic                  busy
);

    state_t r_state;
    state_t w_next;

    logic [CH_W-1:0]         r_ch;
    logic [A_W-1:0]          r_k;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [D_W-1:0]   r_out;
    logic signed [D_W-1:0]   r_x [N_CH][C_NUM];
    logic signed [C_W-1:0]   r_h [C_NUM];

    logic                        w_idle;
    logic                        w_accept;
    logic                        w_ch_ok;
    logic                        w_addr_ok;
    logic                        w_last;
    logic signed [C_W-1:0]       w_h_k;
    logic signed [D_W-1:0]       w_x_k;
    logic signed [D_W+C_W-1:0]   w_prod;
    logic signed [D_W-1:0]       w_round;

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = in_valid & w_idle;
    assign w_ch_ok   = {1'b0, in_ch} < (CH_W+1)'(N_CH);
    assign w_addr_ok = {1'b0, coef_addr} < (A_W+1)'(C_NUM);
    assign w_last    = (r_k == A_W'(C_NUM - 1));

    // Tap operands are muxed onto a single shared multiplier.
    assign w_h_k  = r_h[r_k];
    assign w_x_k  = r_x[r_ch][r_k];
    assign w_prod = w_h_k * w_x_k;

    fir_round_sat #(
        .ACC_W (ACC_W),
        .D_W   (D_W),
        .C_W   (C_W)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_round)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && w_ch_ok) begin
                    w_next = MAC;
                end
            end
            MAC: begin
                if (w_last) begin
                    w_next = ROUND;
                end
            end
            ROUND: begin
                w_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ch  <= '0;
            r_k   <= '0;
            r_acc <= '0;
            r_out <= '0;
            for (int c = 0; c < N_CH; c++) begin
                for (int i = 0; i < C_NUM; i++) begin
                    r_x[c][i] <= '0;
                end
            end
            for (int i = 0; i < C_NUM; i++) begin
                r_h[i] <= '0;
            end
        end else begin
            if (coef_wr_en && w_idle && w_addr_ok) begin
                r_h[coef_addr] <= coef_data;
            end
            case (r_state)
                IDLE: begin
                    // Out-of-range channel tags complete the handshake but are dropped.
                    if (w_accept && w_ch_ok) begin
                        r_ch  <= in_ch;
                        r_k   <= '0;
                        r_acc <= '0;
                        for (int c = 0; c < N_CH; c++) begin
                            if (in_ch == CH_W'(c)) begin
                                for (int i = C_NUM - 1; i > 0; i--) begin
                                    r_x[c][i] <= r_x[c][i-1];
                                end
                                r_x[c][0] <= in_data;
                            end
                        end
                    end
                end
                MAC: begin
                    r_acc <= r_acc + {{(ACC_W-D_W-C_W){w_prod[D_W+C_W-1]}}, w_prod};
                    r_k   <= w_last ? '0 : r_k + 1'b1;
                end
                ROUND: begin
                    r_out <= w_round;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out;
    assign out_ch   = r_ch;

endmodule

// File: tb/tb_fir_multi_ch.sv
// Directed bench for fir_multi_ch: table of sample/expected records plus
// hand-written sequences for backpressure, control hazards and reset abort.
module tb_fir_multi_ch;

    localparam int D_W   = 16;
    localparam int C_W   = 16;
    localparam int C_NUM = 33;
    localparam int N_CH  = 3;
    localparam int LAT   = C_NUM + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        coef_wr_en;
    logic [5:0]  coef_addr;
    logic [15:0] coef_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef enum {OP_H_RAMP, OP_H_ALL, OP_H_ONE, OP_SAMPLE} op_t;
    typedef struct {
        op_t         op;
        logic [1:0]  ch;
        logic [15:0] din;
        logic [15:0] exp;
        bit          chk;
    } vec_t;
    vec_t tbl[$];

    fir_multi_ch #(
        .D_W   (D_W),
        .C_W   (C_W),
        .C_NUM (C_NUM),
        .N_CH  (N_CH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_coef(input logic [5:0] a, input logic [15:0] d);
        @(negedge clock);
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        @(posedge clock);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic load_bank(input op_t mode, input logic [15:0] val);
        logic [15:0] d;
        for (int k = 0; k < C_NUM; k++) begin
            case (mode)
                OP_H_RAMP: d = 16'(256 * (k + 1));
                OP_H_ALL:  d = val;
                default:   d = (k == 0) ? val : 16'h0000;
            endcase
            load_coef(6'(k), d);
        end
    endtask

    // wr_dly < 0: no write; 0: write on the accept edge; n > 0: write n edges into MAC.
    task automatic send(input logic [1:0] ch, input logic [15:0] d, input int wr_dly,
                        input logic [5:0] wa, input logic [15:0] wd,
                        output logic [15:0] od, output logic [1:0] och, output int lat);
        int w;
        @(negedge clock);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_ch    = ch;
        if (wr_dly == 0) begin
            coef_wr_en = 1'b1;
            coef_addr  = wa;
            coef_data  = wd;
        end
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            coef_wr_en = (wr_dly > 0 && lat == wr_dly);
            coef_addr  = wa;
            coef_data  = wd;
            @(posedge clock);
            #1;
            lat++;
        end
        coef_wr_en = 1'b0;
        od  = out_data;
        och = out_ch;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_sample(input string name, input logic [1:0] ch, input logic [15:0] d,
                             input logic [15:0] exp, input bit chk_data,
                             input int wr_dly, input logic [5:0] wa, input logic [15:0] wd);
        logic [15:0] od;
        logic [1:0]  och;
        int          lat;
        send(ch, d, wr_dly, wa, wd, od, och, lat);
        chk({name, " latency"}, 32'(lat), 32'(LAT));
        if (chk_data) begin
            chk({name, " data"}, {16'h0, od}, {16'h0, exp});
            chk({name, " ch"}, {30'h0, och}, {30'h0, ch});
        end
    endtask

    initial begin
        logic [15:0] held;
        int          seen;
        int          w;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_ch      = '0;
        out_ready  = 1'b0;
        coef_wr_en = 1'b0;
        coef_addr  = '0;
        coef_data  = '0;

        // Table: zero-coef check, impulse, channel isolation, saturation, rounding.
        tbl.push_back('{OP_SAMPLE, 2'd0, 16'h7FFF, 16'h0000, 1'b1});
        tbl.push_back('{OP_H_RAMP, 2'd0, 16'h0000, 16'h0000, 1'b0});
        for (int n = 0; n < C_NUM; n++) begin
            tbl.push_back('{OP_SAMPLE, 2'd1, (n == 0) ? 16'h7FFF : 16'h0000,
                            16'(256 * (n + 1)), 1'b1});
        end
        tbl.push_back('{OP_H_ONE, 2'd0, 16'h7FFF, 16'h0000, 1'b0});
        for (int p = 0; p < 4; p++) begin
            tbl.push_back('{OP_SAMPLE, 2'd0, (p == 0) ? 16'h7FFF : 16'h0000,
                            (p == 0) ? 16'h7FFE : 16'h0000, 1'b1});
            tbl.push_back('{OP_SAMPLE, 2'd2, 16'h1000, 16'h1000, 1'b1});
        end
        tbl.push_back('{OP_H_ALL, 2'd0, 16'h7FFF, 16'h0000, 1'b0});
        for (int n = 0; n < C_NUM; n++) begin
            tbl.push_back('{OP_SAMPLE, 2'd1, 16'h7FFF, 16'h7FFF, n == C_NUM - 1});
        end
        for (int n = 0; n < C_NUM; n++) begin
            tbl.push_back('{OP_SAMPLE, 2'd1, 16'h8000, 16'h8000, n == C_NUM - 1});
        end
        tbl.push_back('{OP_H_ONE, 2'd0, 16'h4000, 16'h0000, 1'b0});
        tbl.push_back('{OP_SAMPLE, 2'd2, 16'h0001, 16'h0001, 1'b1});
        tbl.push_back('{OP_SAMPLE, 2'd2, 16'hFFFF, 16'h0000, 1'b1});
        tbl.push_back('{OP_SAMPLE, 2'd2, 16'h0003, 16'h0002, 1'b1});
        tbl.push_back('{OP_SAMPLE, 2'd2, 16'hFFFD, 16'hFFFF, 1'b1});

        repeat (3) @(posedge clock);
        #1;
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_data", {16'h0, out_data}, 32'h0);
        chk("reset out_ch", {30'h0, out_ch}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].op == OP_SAMPLE) begin
                do_sample($sformatf("vec%0d", i), tbl[i].ch, tbl[i].din, tbl[i].exp,
                          tbl[i].chk, -1, 6'd0, 16'h0);
            end else begin
                load_bank(tbl[i].op, tbl[i].din);
            end
        end

        // Out-of-range channel: handshake completes, sample dropped, stays idle.
        @(negedge clock);
        in_valid = 1'b1;
        in_ch    = 2'd3;
        in_data  = 16'h7FFF;
        chk("badch in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("badch busy", {31'h0, busy}, 32'h0);
        chk("badch in_ready after", {31'h0, in_ready}, 32'h1);
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        chk("badch no output", 32'(seen), 32'h0);

        // Backpressure: h[0]=0x4000, sample 2 -> 1.
        @(negedge clock);
        in_valid = 1'b1;
        in_ch    = 2'd2;
        in_data  = 16'h0002;
        @(posedge clock);
        #1;
        in_ch   = 2'd0;
        in_data = 16'h1111;
        w = 0;
        while (!out_valid && w < 200) begin
            @(posedge clock);
            #1;
            w++;
        end
        chk("bp latency", 32'(w), 32'(LAT));
        held = out_data;
        chk("bp data", {16'h0, held}, 32'h0001);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            chk("bp hold valid", {31'h0, out_valid}, 32'h1);
            chk("bp hold data", {16'h0, out_data}, {16'h0, held});
            chk("bp hold ch", {30'h0, out_ch}, 32'h2);
            chk("bp in_ready low", {31'h0, in_ready}, 32'h0);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("bp released valid", {31'h0, out_valid}, 32'h0);
        chk("bp released in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clock);
        #1;
        chk("bp single transfer", {31'h0, out_valid}, 32'h0);
        chk("bp no hidden accept", {31'h0, busy}, 32'h0);

        // Reset mid-MAC aborts the sample.
        @(negedge clock);
        in_valid = 1'b1;
        in_ch    = 2'd1;
        in_data  = 16'h1234;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort busy", {31'h0, busy}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        chk("abort no output", 32'(seen), 32'h0);

        // Coefficients and delay lines must be cleared by the reset.
        do_sample("post-reset zero coef", 2'd0, 16'h7FFF, 16'h0000, 1'b1, -1, 6'd0, 16'h0);
        load_bank(OP_H_RAMP, 16'h0);
        do_sample("clean impulse", 2'd1, 16'h7FFF, 16'h0100, 1'b1, -1, 6'd0, 16'h0);

        // Write during MAC ignored; write on the accept edge takes effect.
        do_sample("mac write", 2'd1, 16'h7FFF, 16'h0300, 1'b1, 5, 6'd0, 16'h7FFF);
        do_sample("mac write readback", 2'd1, 16'h7FFF, 16'h0600, 1'b1, -1, 6'd0, 16'h0);
        do_sample("accept-edge write", 2'd1, 16'h7FFF, 16'h0C00, 1'b1, 0, 6'd0, 16'h0300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_multi_ch.md
FIR_MULTI_CH -- requirements
Module: fir_multi_ch

Interface
REQ-001 Parameter D_W, 16, sample width, signed Q0.(D_W-1).
REQ-002 Parameter C_W, 16, coefficient width, signed Q0.(C_W-1).
REQ-003 Parameter C_NUM, 33, tap count, range 2..64.
REQ-004 Parameter N_CH, 4, channel count, range 1..16; CH_W = max(1, clog2(N_CH)).
REQ-005 The block SHALL have one clock and a synchronous active-high reset, with ports as follows.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid, in_ready, in_data, in_ch  in/out/in/in  1/1/D_W/CH_W  input sample handshake, signed sample, channel tag.
REQ-009 out_valid, out_ready, out_data, out_ch  out/in/out/out  1/1/D_W/CH_W  output handshake, filtered sample, channel tag.
REQ-010 coef_wr_en, coef_addr, coef_data  in/in/in  1/clog2(C_NUM)/C_W  runtime coefficient write port.
REQ-011 busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL keep one C_NUM-deep delay line per channel, x[ch][0] newest, and one coefficient bank h[0..C_NUM-1] shared by all channels.
REQ-013 The FSM SHALL have states IDLE, MAC, ROUND and OUT; in_ready = (state==IDLE), out_valid = (state==OUT).
REQ-014 On an accept edge (in_valid & in_ready) with in_ch < N_CH: shift x[in_ch] by one, load in_data into x[in_ch][0], latch in_ch, clear the accumulator, tap counter k=0, and go to MAC; other channels' lines stay unchanged.
REQ-015 An accept with in_ch >= N_CH SHALL complete the handshake, discard the sample, and remain in IDLE.
REQ-016 MAC SHALL last exactly C_NUM edges, with acc += h[k]*x[ch][k] for k=0..C_NUM-1 and exactly one signed multiply per cycle; the edge with k=C_NUM-1 goes to ROUND.
REQ-017 Accumulator width SHALL be ACC_W = D_W+C_W+clog2(C_NUM); no overflow is possible.
REQ-018 ROUND SHALL register out_data = sat_D_W((acc + 2^(C_W-2)) >>> (C_W-1)), i.e. round half-up toward +inf, then saturate to [-2^(D_W-1), 2^(D_W-1)-1], and go to OUT.
REQ-019 Latency: out_valid SHALL first be high after accept edge E + C_NUM + 1.
REQ-020 In OUT, out_data and out_ch SHALL hold stable until out_valid & out_ready; that edge returns to IDLE (in_ready high in the next cycle); no input is accepted in OUT.
REQ-021 coef_wr_en SHALL write h[coef_addr] only in IDLE and only if coef_addr < C_NUM; otherwise the write is silently ignored.
REQ-022 A coefficient write and an input accept on the same IDLE edge SHALL both take effect, and the ensuing MAC uses the new coefficient.

Reset
REQ-023 Reset SHALL force IDLE, out_valid=0, out_data=0, out_ch=0, busy=0, acc=0, k=0, all delay lines 0, and all coefficients 0.
REQ-024 Reset asserted mid-MAC/ROUND/OUT SHALL abort the operation; no output is produced for the aborted sample.
REQ-025 Reset SHALL take priority over every simultaneous handshake or coefficient write.

Structure
REQ-026 The shared package fir_pkg SHALL hold the state enum type and the ACC_W / CH_W width functions.
REQ-027 The rounding/saturation stage SHALL be a sub-module fir_round_sat (parameters ACC_W, D_W, C_W, purely combinational), registered by the parent.
REQ-028 Delay lines and coefficients SHALL be plain registers; only one multiplier SHALL be inferred.

Verification
REQ-029 Impulse: h[k]=0x0100*(k+1); ch1 gets 0x7FFF then 32 zeros -> outputs 0x0100, 0x0200, ... 0x2100, each with out_ch=1, first out_valid at E+34.
REQ-030 Channel isolation: interleave the ch0 impulse from REQ-029 with constant 0x1000 on ch2, h[0]=0x7FFF and others 0 -> ch2 always outputs 0x1000, and ch0's sequence is unchanged.
REQ-031 Saturation: all h=0x7FFF, 33 samples of 0x7FFF -> final out 0x7FFF; all h=0x7FFF, 33 samples of 0x8000 -> final out 0x8000.
REQ-032 Rounding: h[0]=0x4000, others 0; input 0x0001 -> out 0x0001; input 0xFFFF -> out 0x0000.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles -> out_data/out_ch stable and in_ready=0 throughout; single transfer when out_ready rises.
REQ-034 Control hazards: a coef write during MAC is ignored (readback via impulse unchanged); reset mid-MAC -> out_valid=0, next impulse output equals the clean-start result.
